// File: rtl/arb_if_arbiter.sv
// -----------------------------------------------------------------------------
// arb_if_arbiter
//
// Non-preemptive request/grant arbiter for num_agents requesters.
//
// An agent that owns the grant keeps it for as long as it holds its request
// high. When the owner releases, or when there is no owner, a new owner is
// chosen in the same clock edge from the agents currently requesting.
//
// Selection policy:
//   - default build: round-robin. The search starts at the agent after the
//     last owner and wraps from num_agents-1 to 0. The last-owner pointer
//     changes only when a new grant is issued, so it keeps its value through
//     idle cycles.
//   - with ARB_IF_FIXED_PRIO_EN defined: fixed priority, where the lowest
//     index wins. No pointer register is built. Non-preemption and all
//     timing are the same as in the default build.
//
// Parameters:
//   num_agents  number of requesters, 1..32 (default 1)
//
// Ports:
//   clk        single clock; all state changes on its rising edge
//   reset      asynchronous active-low reset; clears the grant immediately
//   req        request per agent; bit i belongs to agent i
//   gnt        registered grant per agent; always one-hot or all-zero
//   gnt_valid  registered; high exactly when a gnt bit is high
//   gnt_id     registered index of the granted agent; 0 when gnt_valid is low
// -----------------------------------------------------------------------------
module arb_if_arbiter #(
  parameter  int num_agents = 1,
  localparam int ID_W       = (num_agents > 1) ? $clog2(num_agents) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [num_agents-1:0] req,
  output logic [num_agents-1:0] gnt,
  output logic                  gnt_valid,
  output logic [ID_W-1:0]       gnt_id
);

  // Map each request bit to a clean 0/1. An unknown bit does not pass the
  // equality test, so the selection logic sees it as "not requesting".
  function automatic logic [num_agents-1:0] sanitize(
    input logic [num_agents-1:0] v
  );
    logic [num_agents-1:0] c;
    c = '0;
    for (int i = 0; i < num_agents; i++) begin
      if (v[i] == 1'b1) c[i] = 1'b1;
    end
    return c;
  endfunction

  // Index of the lowest set bit. Returns 0 for an all-zero vector; the
  // callers only use the result when the vector is non-zero.
  function automatic logic [ID_W-1:0] lowest_idx(
    input logic [num_agents-1:0] v
  );
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = num_agents - 1; i >= 0; i--) begin
      if (v[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

`ifndef ARB_IF_FIXED_PRIO_EN
  // Bits strictly above the last owner. A round-robin pick is the lowest
  // requester in this window. If nobody in the window is requesting, the
  // search wraps and takes the lowest requester overall.
  function automatic logic [num_agents-1:0] above_mask(
    input logic [ID_W-1:0] p
  );
    logic [num_agents-1:0] m;
    m = '0;
    for (int i = 0; i < num_agents; i++) begin
      m[i] = (ID_W'(i) > p);
    end
    return m;
  endfunction

  logic [ID_W-1:0]       last_ptr;
  logic [num_agents-1:0] upper_p0;
  logic                  new_grant_p0;
`endif

  logic [num_agents-1:0] req_p0;
  logic [num_agents-1:0] hold_p0;
  logic [num_agents-1:0] pick_src_p0;
  logic [num_agents-1:0] gnt_nxt_p0;
  logic [ID_W-1:0]       id_nxt_p0;
  logic                  vld_nxt_p0;

  // Stage p0: decide the grant for the coming edge.
  always_comb begin
    req_p0  = sanitize(req);
    hold_p0 = gnt & req_p0;

`ifdef ARB_IF_FIXED_PRIO_EN
    pick_src_p0 = req_p0;
`else
    upper_p0     = req_p0 & above_mask(last_ptr);
    pick_src_p0  = (upper_p0 != '0) ? upper_p0 : req_p0;
    new_grant_p0 = 1'b0;
`endif

    gnt_nxt_p0 = '0;
    id_nxt_p0  = '0;
    vld_nxt_p0 = 1'b0;

    if (hold_p0 != '0) begin
      // The owner is still requesting, so it keeps the grant.
      gnt_nxt_p0 = gnt;
      id_nxt_p0  = gnt_id;
      vld_nxt_p0 = 1'b1;
    end else if (req_p0 != '0) begin
      // No owner (or the owner just released): hand over in this same edge.
      id_nxt_p0             = lowest_idx(pick_src_p0);
      gnt_nxt_p0[id_nxt_p0] = 1'b1;
      vld_nxt_p0            = 1'b1;
`ifndef ARB_IF_FIXED_PRIO_EN
      new_grant_p0          = 1'b1;
`endif
    end
  end

  // Stage p1: registered grant outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
    end else begin
      gnt       <= gnt_nxt_p0;
      gnt_valid <= vld_nxt_p0;
      gnt_id    <= id_nxt_p0;
    end
  end

`ifndef ARB_IF_FIXED_PRIO_EN
  // The pointer resets to the top agent, so the first search after reset
  // starts at agent 0. It only moves when a new owner is chosen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_ptr <= ID_W'(num_agents - 1);
    end else if (new_grant_p0) begin
      last_ptr <= id_nxt_p0;
    end
  end
`endif

endmodule

// File: tb/tb_arb_if_arbiter.sv
module tb_arb_if_arbiter;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req4  = 4'b0000;
  logic [0:0] req1  = 1'b0;

  logic [3:0] gnt4;
  logic       gv4;
  logic [1:0] gid4;
  logic [0:0] gnt1;
  logic       gv1;
  logic [0:0] gid1;

  arb_if_arbiter #(.num_agents(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .req       (req4),
    .gnt       (gnt4),
    .gnt_valid (gv4),
    .gnt_id    (gid4)
  );

  arb_if_arbiter #(.num_agents(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .req       (req1),
    .gnt       (gnt1),
    .gnt_valid (gv1),
    .gnt_id    (gid1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] g;
    logic       v;
    logic [1:0] id;
    int         tag;
  } exp4_t;

  typedef struct {
    logic g;
    logic v;
    int   tag;
  } exp1_t;

  exp4_t q4[$];
  exp1_t q1[$];
  int    checks = 0;
  int    passes = 0;
  int    tag    = 0;
  event  async_chk;

  task automatic push4(input logic [3:0] g, input logic [1:0] id);
    exp4_t e;
    tag++;
    e.g   = g;
    e.v   = (g != 4'b0000);
    e.id  = id;
    e.tag = tag;
    q4.push_back(e);
  endtask

  task automatic drive4(input logic [3:0] r, input logic [3:0] g, input logic [1:0] id);
    @(negedge clk);
    req4 = r;
    push4(g, id);
  endtask

  task automatic drive1(input logic r, input logic g);
    exp1_t e;
    @(negedge clk);
    req1[0] = r;
    tag++;
    e.g   = g;
    e.v   = g;
    e.tag = tag;
    q1.push_back(e);
  endtask

  // Scoreboard monitor: compares registered outputs just after each edge.
  initial begin : mon
    exp4_t e;
    exp1_t f;
    forever begin
      @(posedge clk);
      #1;
      if (q4.size() > 0) begin
        e = q4.pop_front();
        checks++;
        if (gnt4 === e.g && gv4 === e.v && gid4 === e.id) passes++;
        else $display("FAIL n4_step%0d got gnt=%b valid=%b id=%0d expected gnt=%b valid=%b id=%0d",
                      e.tag, gnt4, gv4, gid4, e.g, e.v, e.id);
      end
      if (q1.size() > 0) begin
        f = q1.pop_front();
        checks++;
        if (gnt1 === f.g && gv1 === f.v && gid1 === 1'b0) passes++;
        else $display("FAIL n1_step%0d got gnt=%b valid=%b id=%0d expected gnt=%b valid=%b id=0",
                      f.tag, gnt1, gv1, gid1, f.g, f.v);
      end
    end
  end

  // Asynchronous reset monitor: outputs must clear without a clock edge.
  initial begin : amon
    forever begin
      @(async_chk);
      checks++;
      if (gnt4 === 4'b0000 && gv4 === 1'b0 && gid4 === 2'd0 &&
          gnt1 === 1'b0 && gv1 === 1'b0 && gid1 === 1'b0) passes++;
      else $display("FAIL async_reset got gnt4=%b v4=%b id4=%0d gnt1=%b v1=%b id1=%0d expected all zero",
                    gnt4, gv4, gid4, gnt1, gv1, gid1);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    #1 reset = 1'b0;
    #2 -> async_chk;
    repeat (2) @(negedge clk);

    // Release and request in the same cycle: first edge grants agent 0.
    @(negedge clk);
    reset = 1'b1;
    req4  = 4'b1111;
    push4(4'b0001, 2'd0);
    drive4(4'b1111, 4'b0001, 2'd0);
    drive4(4'b1111, 4'b0001, 2'd0);
    drive4(4'b1110, 4'b0010, 2'd1);

`ifndef ARB_IF_FIXED_PRIO_EN
    drive4(4'b1110, 4'b0010, 2'd1);
    drive4(4'b1101, 4'b0100, 2'd2);
    drive4(4'b1101, 4'b0100, 2'd2);
    drive4(4'b1011, 4'b1000, 2'd3);
    drive4(4'b1011, 4'b1000, 2'd3);
    drive4(4'b0111, 4'b0001, 2'd0);
    // Make agent 3 the owner, go idle, then check the wrap to agent 0.
    drive4(4'b1000, 4'b1000, 2'd3);
    drive4(4'b1000, 4'b1000, 2'd3);
    for (int i = 0; i < 5; i++) drive4(4'b0000, 4'b0000, 2'd0);
    drive4(4'b0101, 4'b0001, 2'd0);
`else
    drive4(4'b1110, 4'b0010, 2'd1);
    drive4(4'b1101, 4'b0001, 2'd0);
    drive4(4'b1100, 4'b0100, 2'd2);
    drive4(4'b1011, 4'b0001, 2'd0);
    drive4(4'b0000, 4'b0000, 2'd0);
`endif

    // Single-cycle request pulse gives a single-cycle grant.
    drive4(4'b0000, 4'b0000, 2'd0);
    drive4(4'b0100, 4'b0100, 2'd2);
    drive4(4'b0000, 4'b0000, 2'd0);
    drive4(4'b0100, 4'b0100, 2'd2);

    // Asynchronous reset while agent 2 owns the grant.
    @(negedge clk);
    #2 reset = 1'b0;
    #1 -> async_chk;
    req4 = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    req4  = 4'b1100;
    push4(4'b0100, 2'd2);
    drive4(4'b1100, 4'b0100, 2'd2);
    drive4(4'b1000, 4'b1000, 2'd3);
    drive4(4'b0000, 4'b0000, 2'd0);

    // Single-agent instance: grant is the request delayed by one clock.
    drive1(1'b0, 1'b0);
    drive1(1'b1, 1'b1);
    drive1(1'b1, 1'b1);
    drive1(1'b1, 1'b1);
    drive1(1'b0, 1'b0);
    drive1(1'b0, 1'b0);

    repeat (3) @(negedge clk);
    checks++;
    if (q4.size() == 0 && q1.size() == 0) passes++;
    else $display("FAIL drain got %0d/%0d pending expected 0/0", q4.size(), q1.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
